// File: rtl/holoblade_pkg.sv
// Shared definitions for the receive path.
//   rx_state_t     : receive FSM state encoding
//   UART_DATA_BITS : data bits per character
//   SYSCLK_HZ      : system clock frequency the default bit period is derived from
//   even_par()     : even-parity bit for a data word
package holoblade_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int SYSCLK_HZ      = 50250000;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_t;

  // Parity bit that makes the total count of ones (data + parity) even.
  function automatic logic even_par(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Consumer-side bundle of the UART receiver.
//   rx_data     : received byte, valid while rx_valid=1
//   rx_valid    : holding register full
//   rx_ready    : consumer accepts on rx_valid & rx_ready
//   frame_err   : one-cycle pulse, stop bit sampled low
//   overrun_err : one-cycle pulse, byte dropped because the holding register was full
//   parity_err  : one-cycle pulse, parity mismatch (0 when parity is compiled out)
//   busy        : receiver FSM not idle
// master = receiver, slave = consumer.
interface uart_rx_ctrl_if;
  import holoblade_pkg::*;

  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      rx_ready;
  logic                      frame_err;
  logic                      overrun_err;
  logic                      parity_err;
  logic                      busy;

  modport master (
    output rx_data, rx_valid, frame_err, overrun_err, parity_err, busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, overrun_err, parity_err, busy,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_ctrl_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
//   clk : destination clock
//   rst : synchronous active-high reset, loads RST_VAL into both stages
//   d   : asynchronous input
//   q   : synchronised output (two clk cycles of latency)
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 8 data bits, LSB first, one stop bit, with a single-entry
// holding register and valid/ready hand-off to the consumer.
// Build option: define UART_RX_PARITY_EN to expect an even-parity bit between
// the last data bit and the stop bit; otherwise parity_err is tied low.
//   sysclk  : system clock, rising edge
//   reset   : synchronous active-high reset
//   UART_RX : asynchronous serial line, idle high
//   rx_if   : consumer bundle (data/valid/ready, error pulses, busy)
//   CLKS_PER_BIT : sysclk cycles per bit, 8..65535
module uart_rx_ctrl
  import holoblade_pkg::*;
#(
  parameter int CLKS_PER_BIT = 436
) (
  input  logic            sysclk,
  input  logic            reset,
  input  logic            UART_RX,
  uart_rx_ctrl_if.master  rx_if
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t state, state_nxt;

  logic                      rx_s;
  logic                      rx_prev;
  logic [TW-1:0]             timer;
  logic [2:0]                bit_cnt;
  logic [UART_DATA_BITS-1:0] shreg;

  logic                      busy_c;
  logic                      timer_clr;
  logic                      sample;
  logic                      shift_en;
  logic                      done_good;
  logic                      stop_bad;

  logic [UART_DATA_BITS-1:0] data_q;
  logic                      valid_q;
  logic                      frame_err_q;
  logic                      overrun_q;

`ifdef UART_RX_PARITY_EN
  logic                      par_bad;
  logic                      par_chk;
  logic                      done_perr;
  logic                      parity_err_q;
`endif

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (sysclk),
    .rst (reset),
    .d   (UART_RX),
    .q   (rx_s)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge sysclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (rx_prev && !rx_s) state_nxt = START;
      // Mid-start-bit check; a high line here was only a glitch.
      START:     if (timer == HALF_END) state_nxt = rx_s ? IDLE : DATA;
      DATA:      if (timer == BIT_END && bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                   state_nxt = PARITY;
`else
                   state_nxt = STOP;
`endif
                 end
      PARITY:    if (timer == BIT_END) state_nxt = STOP;
      STOP:      if (timer == BIT_END) state_nxt = rx_s ? IDLE : WAIT_IDLE;
      // A low stop bit may be a break; hold off until the line recovers.
      WAIT_IDLE: if (rx_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs / datapath strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_c    = (state != IDLE);
    sample    = 1'b0;
    shift_en  = 1'b0;
    done_good = 1'b0;
    stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_chk   = 1'b0;
    done_perr = 1'b0;
`endif
    unique case (state)
      START:  sample = (timer == HALF_END);
      DATA:   begin
                sample   = (timer == BIT_END);
                shift_en = sample;
              end
      PARITY: begin
                sample = (timer == BIT_END);
`ifdef UART_RX_PARITY_EN
                par_chk = sample;
`endif
              end
      STOP:   begin
                sample   = (timer == BIT_END);
                stop_bad = sample && !rx_s;
`ifdef UART_RX_PARITY_EN
                done_good = sample && rx_s && !par_bad;
                done_perr = sample && rx_s && par_bad;
`else
                done_good = sample && rx_s;
`endif
              end
      default: ;
    endcase
    // Timer idles at 0 outside a frame so START always begins from a clean count.
    timer_clr = sample || (state == IDLE) || (state == WAIT_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Bit timer, bit counter, shift register
  // ---------------------------------------------------------------------------
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_prev <= 1'b1;
      timer   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      rx_prev <= rx_s;
      timer   <= timer_clr ? '0 : timer + 1'b1;
      if (state == START) begin
        bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
        par_bad <= 1'b0;
`endif
      end
      if (shift_en) begin
        shreg   <= {rx_s, shreg[UART_DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
`ifdef UART_RX_PARITY_EN
      if (par_chk) par_bad <= (rx_s != even_par(shreg));
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Holding register and error pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge sysclk) begin
    if (reset) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= stop_bad;
      overrun_q   <= 1'b0;
      if (valid_q && rx_if.rx_ready) valid_q <= 1'b0;
      if (done_good) begin
        // A same-cycle hand-off frees the register, so the new byte fits.
        if (!valid_q || rx_if.rx_ready) begin
          data_q  <= shreg;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge sysclk) begin
    if (reset) parity_err_q <= 1'b0;
    else       parity_err_q <= done_perr;
  end
  assign rx_if.parity_err = parity_err_q;
`else
  assign rx_if.parity_err = 1'b0;
`endif

  assign rx_if.rx_data     = data_q;
  assign rx_if.rx_valid    = valid_q;
  assign rx_if.frame_err   = frame_err_q;
  assign rx_if.overrun_err = overrun_q;
  assign rx_if.busy        = busy_c;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed + randomized bench for uart_rx_ctrl at CLKS_PER_BIT=16.
// Inputs change 2 time units after a rising edge; a negedge monitor logs
// accepted bytes and error pulses; checks run after the input updates.
module tb_uart_rx_ctrl;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Rising edge (counted from the start-bit drive) on which the stop bit is
  // sampled: 2 sync flops + edge detect, half a bit, then one bit per remaining bit.
  localparam int DONE_EDGE = 3 + HALF + CPB * (NBITS - 1);

  logic sysclk  = 1'b0;
  logic reset   = 1'b1;
  logic UART_RX = 1'b1;
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  always #5 sysclk = ~sysclk;

  uart_rx_ctrl_if bus();

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .sysclk  (sysclk),
    .reset   (reset),
    .UART_RX (UART_RX),
    .rx_if   (bus)
  );

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int n_fe = 0, n_oe = 0, n_pe = 0, n_stab = 0;
  int exp_fe = 0, exp_oe = 0, exp_pe = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  // Monitor: accepted bytes, error pulse cycles, rx_data stability while held.
  logic       prev_v = 1'b0, prev_hs = 1'b0;
  logic [7:0] prev_d = 8'h00;
  always @(negedge sysclk) begin
    if (bus.rx_valid && bus.rx_ready) got.push_back(bus.rx_data);
    if (bus.frame_err)   n_fe++;
    if (bus.overrun_err) n_oe++;
    if (bus.parity_err)  n_pe++;
    if (prev_v && !prev_hs && bus.rx_valid && bus.rx_data !== prev_d) n_stab++;
    prev_v  = bus.rx_valid;
    prev_hs = bus.rx_valid && bus.rx_ready;
    prev_d  = bus.rx_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Compare the scoreboard against the monitor, then start a fresh window.
  task automatic check_all(input string tag);
    chk({tag, "_nbytes"}, 32'(got.size()), 32'(exp_q.size()));
    chk({tag, "_frame_err"}, 32'(n_fe), 32'(exp_fe));
    chk({tag, "_overrun"}, 32'(n_oe), 32'(exp_oe));
    chk({tag, "_parity_err"}, 32'(n_pe), 32'(exp_pe));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sysclk);
    #2;
  endtask

  // Drives start, data (LSB first), optional parity, then leaves the line at
  // stop_bit for stop_cycles; the caller decides when the line returns high.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_cycles);
    @(posedge sysclk); #2 UART_RX = 1'b0;
    repeat (CPB) @(posedge sysclk);
    for (int i = 0; i < 8; i++) begin
      #2 UART_RX = b[i];
      repeat (CPB) @(posedge sysclk);
    end
`ifdef UART_RX_PARITY_EN
    #2 UART_RX = (^b) ^ par_flip;
    repeat (CPB) @(posedge sysclk);
`endif
    #2 UART_RX = stop_bit;
    repeat (stop_cycles) @(posedge sysclk);
  endtask

  initial begin
    logic [7:0] b;
    bit         bad;

    bus.rx_ready = 1'b1;
    reset = 1'b1;
    idle(4);
    chk("rst_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst_data", 32'(bus.rx_data), 32'h00);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_fe", 32'(bus.frame_err), 32'd0);
    chk("rst_oe", 32'(bus.overrun_err), 32'd0);
    chk("rst_pe", 32'(bus.parity_err), 32'd0);
    reset = 1'b0;
    idle(10);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // Plain byte
    send_frame(8'hA5, 1'b1, CPB);
    exp_q.push_back(8'hA5);
    idle(20);
    chk("a5_valid_cleared", 32'(bus.rx_valid), 32'd0);
    check_all("a5");

    // Short low glitch on an idle line
    @(posedge sysclk); #2 UART_RX = 1'b0;
    repeat (4) @(posedge sysclk);
    #2 UART_RX = 1'b1;
    repeat (3) @(posedge sysclk);
    #2 chk("glitch_busy_start", 32'(bus.busy), 32'd1);
    idle(20);
    chk("glitch_busy_idle", 32'(bus.busy), 32'd0);
    check_all("glitch");

    // Stop bit held low (break-like)
    send_frame(8'h3C, 1'b0, 40);
    #2;
    exp_fe++;
    chk("fe_busy_low_line", 32'(bus.busy), 32'd1);
    chk("fe_count_mid", 32'(n_fe), 32'(exp_fe));
    UART_RX = 1'b1;
    idle(10);
    chk("fe_busy_after", 32'(bus.busy), 32'd0);
    check_all("frame");

    // Overrun: consumer stalled across two bytes
    bus.rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, CPB);
    idle(8);
    send_frame(8'h22, 1'b1, CPB);
    idle(20);
    exp_oe++;
    chk("ovr_valid", 32'(bus.rx_valid), 32'd1);
    chk("ovr_data_kept", 32'(bus.rx_data), 32'h11);
    bus.rx_ready = 1'b1;
    idle(2);
    bus.rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    chk("ovr_drained", 32'(bus.rx_valid), 32'd0);
    check_all("overrun");

    // Same-cycle hand-off at completion: no overrun, new byte replaces old
    send_frame(8'h11, 1'b1, CPB);
    idle(8);
    fork
      send_frame(8'h22, 1'b1, CPB);
      begin
        @(posedge sysclk); #2;
        repeat (DONE_EDGE - 1) @(posedge sysclk);
        #2 bus.rx_ready = 1'b1;
        @(posedge sysclk);
        #2 bus.rx_ready = 1'b0;
      end
    join
    idle(20);
    exp_q.push_back(8'h11);
    chk("swap_valid", 32'(bus.rx_valid), 32'd1);
    chk("swap_data", 32'(bus.rx_data), 32'h22);
    bus.rx_ready = 1'b1;
    idle(2);
    exp_q.push_back(8'h22);
    check_all("swap");

    // Random bytes, some with a bad stop bit
    for (int n = 0; n < 16; n++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      send_frame(b, !bad, CPB);
      #2 UART_RX = 1'b1;
      if (bad) exp_fe++;
      else     exp_q.push_back(b);
      idle($urandom_range(4, 30));
    end
    idle(20);
    check_all("random");

`ifdef UART_RX_PARITY_EN
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, CPB);
    idle(20);
    exp_pe++;
    check_all("par_bad");
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1, CPB);
    idle(20);
    exp_q.push_back(8'h07);
    check_all("par_good");
`endif

    // Leave a byte held, then reset in the middle of the next frame
    bus.rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1, CPB);
    idle(20);
    chk("hold_valid", 32'(bus.rx_valid), 32'd1);
    chk("hold_data", 32'(bus.rx_data), 32'h5A);
    b = 8'h55;
    @(posedge sysclk); #2 UART_RX = 1'b0;
    repeat (CPB) @(posedge sysclk);
    for (int i = 0; i < 4; i++) begin
      #2 UART_RX = b[i];
      repeat (CPB) @(posedge sysclk);
    end
    #2 UART_RX = b[4];
    repeat (HALF) @(posedge sysclk);
    #2 reset = 1'b1;
    idle(2);
    chk("mid_rst_valid", 32'(bus.rx_valid), 32'd0);
    chk("mid_rst_data", 32'(bus.rx_data), 32'h00);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_fe", 32'(bus.frame_err), 32'd0);
    chk("mid_rst_oe", 32'(bus.overrun_err), 32'd0);
    chk("mid_rst_pe", 32'(bus.parity_err), 32'd0);
    bus.rx_ready = 1'b1;
    UART_RX = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(40);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    send_frame(8'h81, 1'b1, CPB);
    idle(20);
    exp_q.push_back(8'h81);
    check_all("post_rst");

    chk("data_stable_while_valid", 32'(n_stab), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 436, sysclk cycles per UART bit (50.25 MHz / 115200); legal range 8..65535.
REQ-002 SHALL have port sysclk  input  1  system clock (50.25 MHz PLL global clock); all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port UART_RX  input  1  asynchronous serial line, idle high, 8 data bits, LSB first.
REQ-005 SHALL have port rx_data  output  8  received byte; valid while rx_valid=1.
REQ-006 SHALL have port rx_valid  output  1  byte available in holding register.
REQ-007 SHALL have port rx_ready  input  1  consumer accepts byte on a cycle where rx_valid=1 and rx_ready=1.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port overrun_err  output  1  one-cycle pulse: new byte completed while holding register still full.
REQ-010 SHALL have port parity_err  output  1  one-cycle pulse: parity mismatch (tied 0 when parity compiled out).
REQ-011 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-012 SHALL synchronise UART_RX through a 2-flop synchroniser reset to 1; all decisions use the synchronised value.
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-014 IDLE: on synchronised line 1->0 transition, go to START and clear the bit-timer.
REQ-015 START: after CLKS_PER_BIT/2 cycles (integer division), sample; if 0, go to DATA; if 1, treat as glitch and return to IDLE with no flag.
REQ-016 DATA: sample every CLKS_PER_BIT cycles, shift into bits LSB first; after bit 7, go to PARITY if enabled, else STOP.
REQ-017 PARITY: sample after CLKS_PER_BIT cycles and compare to even parity of the 8 data bits; record the mismatch.
REQ-018 STOP: sample after CLKS_PER_BIT cycles; if 1, complete the byte and return to IDLE the next cycle.
REQ-019 STOP: if sampled 0, pulse frame_err, discard the byte, and go to WAIT_IDLE.
REQ-020 WAIT_IDLE: remain until synchronised line = 1, then go to IDLE; this covers the break condition.
REQ-021 Byte completion with parity mismatch SHALL pulse parity_err and discard the byte.
REQ-022 Good byte completion with rx_valid=0 SHALL load rx_data and set rx_valid on the next cycle.
REQ-023 Good byte completion with rx_valid=1 and rx_ready=1 in the same cycle SHALL accept the old byte, load the new byte, keep rx_valid=1, and assert no overrun.
REQ-024 Good byte completion with rx_valid=1 and rx_ready=0 SHALL keep the old byte, drop the new byte, and pulse overrun_err.
REQ-025 rx_valid SHALL clear the cycle after a handshake unless REQ-023 applies; rx_data SHALL remain stable while rx_valid=1.
REQ-026 Bit-timer width SHALL be $clog2(CLKS_PER_BIT) bits; the timer SHALL reset to 0 on every sample.

Reset
REQ-027 On reset: FSM=IDLE, timer=0, shift register=0, synchroniser=1, rx_data=0x00, rx_valid=0, all error pulses=0, busy=0.
REQ-028 Reset mid-frame SHALL abandon the frame without flags; the next falling edge after reset SHALL start a fresh frame.

Configuration
REQ-029 Macro UART_RX_PARITY_EN SHALL control parity support.
REQ-030 When defined, the frame is start + 8 data + even parity + stop, and the PARITY state is used.
REQ-031 When undefined, the frame is start + 8 data + stop, the PARITY state is unreachable or omitted, and parity_err is tied to 0.

Structure
REQ-032 Shared package holoblade_pkg SHALL hold the FSM state enum, UART_DATA_BITS=8, and SYSCLK_HZ=50250000.
REQ-033 SHALL instantiate sub-module sync_2ff for UART_RX synchronisation; all other logic stays in uart_rx_ctrl.

Verification (CLKS_PER_BIT=16)
REQ-034 Send 0xA5 with good stop bit, rx_ready=1 -> rx_valid pulses with rx_data=0xA5; no error flags.
REQ-035 Low glitch of 4 cycles on an idle line -> FSM returns to IDLE; no rx_valid; no flags.
REQ-036 Send 0x3C with stop bit held 0 for 40 cycles -> frame_err pulses once; no rx_valid; busy stays high until the line returns to 1.
REQ-037 Send 0x11 then 0x22 with rx_ready=0 -> rx_data=0x11 is retained and overrun_err pulses once at 0x22 completion; repeat with rx_ready=1 at that exact cycle -> rx_data=0x22 and no overrun.
REQ-038 With UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 (wrong) -> parity_err pulses and the byte is discarded; with parity bit 1 -> rx_data=0x07.
REQ-039 Assert reset at data bit 4 of 0x55 -> all outputs return to reset values; a following 0x81 is received correctly.
